// File: rtl/gate_selftest_pkg.sv
// Shared definitions for the 2-input cell self-test sequencer.
//   state_t          : sequencer states (2-bit encoding)
//   VEC_IDX_W/ERR_W  : vector-index and error-count widths
//   NUM_VEC          : number of input vectors for a 2-input cell
//   TT_*             : expected-output tables, bit i = Output for vector {B,A}=i
package gate_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int VEC_IDX_W = 2;
  localparam int ERR_W     = 3;
  localparam int NUM_VEC   = 4;

  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate2_selftest.sv
// Stimulus-and-check sequencer for one 2-input library cell (BIST).
// Walks {B,A} through 0..3 (A toggles fastest), waits SETTLE_CYCLES after
// each drive, samples the cell Output and compares against TRUTH.
//
// state  | meaning
// IDLE   | waiting for Start, A/B parked at 0, results held
// SETTLE | vector driven, counting settle cycles in wcnt
// SAMPLE | compare Output with TRUTH[idx], advance or finish
// DONE   | one-cycle Done pulse, Pass/ErrCount/FailMask final
//
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   Start          : one-cycle request, ignored unless idle
//   Output         : output of the gate under test
//   A, B           : gate input drives
//   Busy, Done     : test in progress / end-of-test pulse
//   Pass, ErrCount, FailMask : results, held until next accepted Start
module gate2_selftest
  import gate_selftest_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH         = TT_AND,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Output,
  output logic             A,
  output logic             B,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount,
  output logic [NUM_VEC-1:0] FailMask
);

  localparam logic [3:0] WCNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [VEC_IDX_W-1:0] idx, idx_nxt;
  logic [3:0]           wcnt, wcnt_nxt;
  logic                 a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]     err_nxt;
  logic [NUM_VEC-1:0]   mask_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      wcnt     <= '0;
      A        <= 1'b0;
      B        <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      FailMask <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wcnt     <= wcnt_nxt;
      A        <= a_nxt;
      B        <= b_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
      Pass     <= pass_nxt;
      ErrCount <= err_nxt;
      FailMask <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    a_nxt     = A;
    b_nxt     = B;
    busy_nxt  = Busy;
    done_nxt  = 1'b0;
    pass_nxt  = Pass;
    err_nxt   = ErrCount;
    mask_nxt  = FailMask;
    case (state)
      IDLE: begin
        if (Start) begin
          idx_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          err_nxt   = '0;
          mask_nxt  = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          wcnt_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        wcnt_nxt = wcnt + 4'd1;
        if (wcnt == WCNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (Output != TRUTH[idx]) begin
          err_nxt       = ErrCount + 3'd1;
          mask_nxt[idx] = 1'b1;
        end
        if (idx == 2'd3) begin
          // Pass must already include the last vector's result when Done rises.
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 2'd1;
          a_nxt     = idx_nxt[0];
          b_nxt     = idx_nxt[1];
          wcnt_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        a_nxt     = 1'b0;
        b_nxt     = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate2_selftest.sv
// Self-checking bench for gate2_selftest. Three instances with different
// TRUTH/SETTLE_CYCLES; each drives a behavioural gate model (table + latency).
module tb_gate2_selftest;
  import gate_selftest_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       st    [3];
  logic       out_w [3];
  logic       a_o   [3];
  logic       b_o   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [2:0] errc  [3];
  logic [3:0] mask  [3];
  logic [3:0] tt    [3];
  int         dly   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate2_selftest #(.TRUTH(TT_AND), .SETTLE_CYCLES(2)) u_d0 (
    .CLK(clk), .RST(rst), .Start(st[0]), .Output(out_w[0]), .A(a_o[0]), .B(b_o[0]),
    .Busy(busy[0]), .Done(done[0]), .Pass(pass[0]), .ErrCount(errc[0]), .FailMask(mask[0]));
  gate2_selftest #(.TRUTH(TT_OR), .SETTLE_CYCLES(1)) u_d1 (
    .CLK(clk), .RST(rst), .Start(st[1]), .Output(out_w[1]), .A(a_o[1]), .B(b_o[1]),
    .Busy(busy[1]), .Done(done[1]), .Pass(pass[1]), .ErrCount(errc[1]), .FailMask(mask[1]));
  gate2_selftest #(.TRUTH(TT_AND), .SETTLE_CYCLES(3)) u_d2 (
    .CLK(clk), .RST(rst), .Start(st[2]), .Output(out_w[2]), .A(a_o[2]), .B(b_o[2]),
    .Busy(busy[2]), .Done(done[2]), .Pass(pass[2]), .ErrCount(errc[2]), .FailMask(mask[2]));

  // Gate models: output = table lookup of {B,A}, optionally delayed 1 or 2 cycles.
  for (genvar g = 0; g < 3; g++) begin : g_gate
    logic [1:0] ab_d1 = 2'b00;
    logic [1:0] ab_d2 = 2'b00;
    always_ff @(posedge clk) begin
      ab_d1 <= {b_o[g], a_o[g]};
      ab_d2 <= ab_d1;
    end
    assign out_w[g] = (dly[g] == 0) ? tt[g][{b_o[g], a_o[g]}] :
                      (dly[g] == 1) ? tt[g][ab_d1] : tt[g][ab_d2];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector index whose value the gate presents at the k-th sample edge:
  // the sample at edge (k+1)(s+1) sees {B,A} as it was after edge (k+1)(s+1)-1-dl,
  // and vector j is applied from edge j(s+1).
  function automatic int seen_idx(int k, int s, int dl);
    int x;
    x = (k + 1) * (s + 1) - 1 - dl;
    if (x < 0) return 0;
    return (x / (s + 1) > 3) ? 3 : x / (s + 1);
  endfunction

  task automatic run_test(input int d, input int s, input logic [3:0] truth,
                          input logic [3:0] gate_tt, input int gate_dly,
                          input bit repulse, input int gap);
    logic [3:0] em;
    int         ec;
    int         last;
    int         v;
    logic       seen;
    tt[d]  = gate_tt;
    dly[d] = gate_dly;
    em = '0;
    ec = 0;
    for (int k = 0; k < 4; k++) begin
      seen = gate_tt[seen_idx(k, s, gate_dly)];
      if (seen != truth[k]) begin
        em[k] = 1'b1;
        ec++;
      end
    end
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    last = 4 * (s + 1);
    st[d] = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n <= last + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      st[d] = 1'b0;
      v = (n <= last) ? ((n / (s + 1) > 3) ? 3 : n / (s + 1)) : 0;
      check("ab_vector", {6'd0, b_o[d], a_o[d]}, 8'(v));
      check("busy", {7'd0, busy[d]}, {7'd0, (n <= last)});
      check("done", {7'd0, done[d]}, {7'd0, (n == last)});
      if (n == 0) begin
        check("pass_cleared", {7'd0, pass[d]}, 8'd0);
        check("err_cleared", {5'd0, errc[d]}, 8'd0);
        check("mask_cleared", {4'd0, mask[d]}, 8'd0);
      end
      if (n == last) begin
        check("pass", {7'd0, pass[d]}, {7'd0, (ec == 0)});
        check("errcount", {5'd0, errc[d]}, 8'(ec));
        check("failmask", {4'd0, mask[d]}, {4'd0, em});
      end
      if (repulse && (n + 1 == 4 || n + 1 == last || n + 1 == last + 1)) st[d] = 1'b1;
    end
    st[d] = 1'b0;
    check("pass_held", {7'd0, pass[d]}, {7'd0, (ec == 0)});
    check("err_held", {5'd0, errc[d]}, 8'(ec));
    check("mask_held", {4'd0, mask[d]}, {4'd0, em});
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_a"},    {7'd0, a_o[d]},  8'd0);
    check({tag, "_b"},    {7'd0, b_o[d]},  8'd0);
    check({tag, "_busy"}, {7'd0, busy[d]}, 8'd0);
    check({tag, "_done"}, {7'd0, done[d]}, 8'd0);
    check({tag, "_pass"}, {7'd0, pass[d]}, 8'd0);
    check({tag, "_err"},  {5'd0, errc[d]}, 8'd0);
    check({tag, "_mask"}, {4'd0, mask[d]}, 8'd0);
  endtask

  initial begin
    int d, dl;
    logic [3:0] rt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      tt[i]  = TT_AND;
      dly[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;

    // Good and2, stuck-at-0, stuck-at-1.
    run_test(0, 2, TT_AND, TT_AND, 0, 1'b0, 3);
    run_test(0, 2, TT_AND, 4'b0000, 0, 1'b0, 3);
    run_test(0, 2, TT_AND, 4'b1111, 0, 1'b0, 3);
    // OR checker, settle 1: good OR then an AND cell in its place.
    run_test(1, 1, TT_OR, TT_OR, 0, 1'b0, 3);
    run_test(1, 1, TT_OR, TT_AND, 0, 1'b0, 3);
    // Start re-pulsed mid-test and during DONE, then back-to-back start.
    run_test(0, 2, TT_AND, 4'b0000, 0, 1'b1, 3);
    run_test(0, 2, TT_AND, TT_AND, 0, 1'b0, 0);

    // Reset while idx=2 (after edge 7 with settle 2).
    tt[0] = TT_AND; dly[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_b_before_rst", {7'd0, b_o[0]}, 8'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero(0, "midrst");
    repeat (4) @(posedge clk);
    #1;
    check_zero(0, "post_rst_idle");
    run_test(0, 2, TT_AND, TT_AND, 0, 1'b0, 2);

    // Slow cell: 2-cycle output latency.
    run_test(1, 1, TT_OR, TT_OR, 2, 1'b0, 3);
    run_test(2, 3, TT_AND, TT_AND, 2, 1'b0, 3);

    // Randomized cell behaviour and latency on all instances.
    for (int r = 0; r < 15; r++) begin
      d  = int'($urandom_range(0, 2));
      rt = 4'($urandom_range(0, 15));
      dl = int'($urandom_range(0, 2));
      case (d)
        0:       run_test(0, 2, TT_AND, rt, dl, 1'b0, 3);
        1:       run_test(1, 1, TT_OR,  rt, dl, 1'b0, 3);
        default: run_test(2, 3, TT_AND, rt, dl, 1'b0, 3);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate2_selftest.md
Name: gate2_selftest

Overview:
Stimulus-and-check sequencer for 2-input library cells in the 4-bit ALU cell set: the other end of a gate's A/B→Output interface.
- Drives A/B through all four input vectors, in the same order as the cell-level simulation stimulus (A toggles fastest).
- Waits a programmable settle time, samples the gate's Output and compares it against a parameterised truth table.
- Reports pass/fail, an error count and a per-vector failure mask; used as on-chip BIST for the and2/or2/nand2 cells.

Parameters:
TRUTH, 4'b1000, expected Output for vector index {B,A}; bit i is the expected value for index i; default is AND.
SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling Output; legal range 1..15.

Ports:
CLK  input  1  single clock, rising edge.
RST  input  1  synchronous, active-high reset.
Start  input  1  one-cycle request to run a test; ignored unless idle.
Output  input  1  Output of the gate under test.
A  output  1  gate input A drive.
B  output  1  gate input B drive.
Busy  output  1  high from the Start acceptance edge until the DONE state is left.
Done  output  1  one-cycle pulse at end of test.
Pass  output  1  1 if all four vectors matched; valid from Done, held until next accepted Start.
ErrCount  output  3  number of mismatching vectors, 0..4; held like Pass.
FailMask  output  4  bit i set if vector index i mismatched; held like Pass.

Behaviour:
- Clocking: one clock (CLK); reset is synchronous and active-high (RST); all outputs registered.
- Reset values: A=0, B=0, Busy=0, Done=0, Pass=0, ErrCount=0, FailMask=0, state=IDLE, idx=0, wcnt=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, Start=1: A=0, B=0 (idx=0); clear ErrCount, FailMask and Pass; Busy=1; wcnt=0; go to SETTLE.
- SETTLE: wcnt+1 each cycle; when wcnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - If Output != TRUTH[idx]: ErrCount+1 and FailMask[idx]=1.
  - If idx==3: go to DONE.
  - Else: idx+1, A=idx_next[0], B=idx_next[1], wcnt=0, go to SETTLE.
- DONE: Done=1 for exactly this cycle. Pass=(ErrCount==0) is computed including the vector-3 result. Next edge: Busy=0, state IDLE.
- Vector order as (A,B): (0,0), (1,0), (0,1), (1,1).
- Latency: with the Start edge as edge 0, vector k is sampled at edge (k+1)(SETTLE_CYCLES+1). Done is high in the cycle after edge 4(SETTLE_CYCLES+1); Busy drops one edge later.
- A/B change only on SAMPLE→SETTLE transitions and on Start acceptance; they hold vector 3 through DONE and return to 0 when IDLE is re-entered.
- Start while Busy, including during DONE: ignored; no restart and no effect on results.
- RST mid-test: immediate return to reset values; the partial result is discarded. The next Start runs a full test.
- ErrCount cannot exceed 4, so no saturation logic is needed.
- Output is treated as 2-state. X/Z handling is the bench's responsibility.

Decomposition:
- Shared package gate_selftest_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE), 2-bit encoding;
  - VEC_IDX_W=2, ERR_W=3, NUM_VEC=4;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
- No sub-module required. The settle counter and vector index stay inline in gate2_selftest.

Test Plan:
1. Default params, correct and2 connected, pulse Start → A,B sequence (0,0),(1,0),(0,1),(1,1) at edges 0,3,6,9; Done pulse after edge 12; Pass=1, ErrCount=0, FailMask=4'b0000.
2. Output stuck-at-0 → Pass=0, ErrCount=1, FailMask=4'b1000. Output stuck-at-1 → ErrCount=3, FailMask=4'b0111.
3. TRUTH=TT_OR, SETTLE_CYCLES=1, correct OR model → Done after edge 8, Pass=1. Then swap in the AND model → ErrCount=2, FailMask=4'b0110.
4. Start re-pulsed at edges 4 and 12 (DONE cycle) → single Done, results unchanged, Busy low after edge 13; Start at edge 14 → new test runs.
5. RST asserted while idx=2 → next cycle all outputs 0 and state IDLE; a following Start with a good DUT gives Pass=1.
6. Slow DUT model, Output delayed 2 cycles, with SETTLE_CYCLES=1 → mismatches flagged (FailMask≠0). With SETTLE_CYCLES=3 → Pass=1.
